// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_pkg
// Purpose  : Shared types, default raster constants and config helpers for
//            the programmable raster timing generator.
// Contents : timing_axis_t (active / front porch / sync / back porch),
//            DEF_* default 640x480 timing, axis_total(), axis_valid().
// Revision : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

    // One axis of raster timing, laid out in emission order.
    typedef struct packed {
        logic [11:0] active;
        logic [11:0] fp;
        logic [11:0] sync;
        logic [11:0] bp;
    } timing_axis_t;

    localparam int DEF_HA  = 640;
    localparam int DEF_HFP = 16;
    localparam int DEF_HS  = 96;
    localparam int DEF_HBP = 48;
    localparam int DEF_VA  = 480;
    localparam int DEF_VFP = 10;
    localparam int DEF_VS  = 2;
    localparam int DEF_VBP = 33;

    // Total period of an axis; 14 bits so four 12-bit terms cannot overflow.
    function automatic logic [13:0] axis_total(input timing_axis_t a);
        return {2'b00, a.active} + {2'b00, a.fp} + {2'b00, a.sync} + {2'b00, a.bp};
    endfunction

    // An axis needs a non-empty active and sync region and must fit a
    // 12-bit counter.
    function automatic logic axis_valid(input timing_axis_t a);
        return (a.active != 12'd0) && (a.sync != 12'd0) &&
               (axis_total(a) <= 14'd4095);
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_axis.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_axis
// Purpose  : One raster axis: position counter, end-of-period detect and
//            active / sync region decode.
// Ports    : clk, rst_n  - clock, async active-low reset
//            step        - advance the counter by one
//            cfg         - shadowed timing for this axis
//            cnt         - current position
//            active      - cnt inside the active region
//            sync        - cnt inside the sync region
//            wrap        - cnt is the last position of the period
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_axis import video_timing_pkg::*; (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    input  timing_axis_t cfg,
    output logic [11:0]  cnt,
    output logic         active,
    output logic         sync,
    output logic         wrap
);

    logic [13:0] last_idx;
    logic [13:0] sync_start;
    logic [13:0] sync_end;
    logic [13:0] cnt_ext;

    assign cnt_ext    = {2'b00, cnt};
    assign last_idx   = axis_total(cfg) - 14'd1;
    assign sync_start = {2'b00, cfg.active} + {2'b00, cfg.fp};
    assign sync_end   = sync_start + {2'b00, cfg.sync};

    assign wrap   = (cnt_ext == last_idx);
    assign active = (cnt < cfg.active);
    assign sync   = (cnt_ext >= sync_start) && (cnt_ext < sync_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 12'd0;
        end else if (step) begin
            cnt <= wrap ? 12'd0 : cnt + 12'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Purpose  : Programmable raster timing generator driving VGA_HS / VGA_VS /
//            VGA_DE. Requested timing is sampled only at the last pixel of a
//            frame, so every frame is emitted with one consistent geometry.
// Ports    : CLK_VIDEO, RESET_N     - clock, async active-low reset
//            CE_PIXEL               - pixel enable, all timing advances on it
//            H_* / V_*              - requested timing (12 bits each)
//            VGA_HS, VGA_VS, VGA_DE - active-high sync and display enable
//            HCNT, VCNT             - position of the emitted pixel
//            FRAME_START            - one-clock pulse when (0,0) is emitted
//            CFG_ERR                - last frame-boundary sample was invalid
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen import video_timing_pkg::*; #(
    parameter int DEF_HA  = video_timing_pkg::DEF_HA,
    parameter int DEF_HFP = video_timing_pkg::DEF_HFP,
    parameter int DEF_HS  = video_timing_pkg::DEF_HS,
    parameter int DEF_HBP = video_timing_pkg::DEF_HBP,
    parameter int DEF_VA  = video_timing_pkg::DEF_VA,
    parameter int DEF_VFP = video_timing_pkg::DEF_VFP,
    parameter int DEF_VS  = video_timing_pkg::DEF_VS,
    parameter int DEF_VBP = video_timing_pkg::DEF_VBP
) (
    input  logic        CLK_VIDEO,
    input  logic        RESET_N,
    input  logic        CE_PIXEL,
    input  logic [11:0] H_ACTIVE,
    input  logic [11:0] H_FP,
    input  logic [11:0] H_SYNC,
    input  logic [11:0] H_BP,
    input  logic [11:0] V_ACTIVE,
    input  logic [11:0] V_FP,
    input  logic [11:0] V_SYNC,
    input  logic [11:0] V_BP,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_DE,
    output logic [11:0] HCNT,
    output logic [11:0] VCNT,
    output logic        FRAME_START,
    output logic        CFG_ERR
);

    localparam timing_axis_t H_DEFAULT = {12'(DEF_HA), 12'(DEF_HFP), 12'(DEF_HS), 12'(DEF_HBP)};
    localparam timing_axis_t V_DEFAULT = {12'(DEF_VA), 12'(DEF_VFP), 12'(DEF_VS), 12'(DEF_VBP)};

    timing_axis_t h_shadow;
    timing_axis_t v_shadow;
    timing_axis_t h_req;
    timing_axis_t v_req;

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        h_active;
    logic        v_active;
    logic        h_sync;
    logic        v_sync;
    logic        h_wrap;
    logic        v_wrap;
    logic        frame_end;
    logic        req_ok;

    assign h_req = {H_ACTIVE, H_FP, H_SYNC, H_BP};
    assign v_req = {V_ACTIVE, V_FP, V_SYNC, V_BP};

    // Last pixel of the last line: counters wrap and the shadow reloads on
    // the same edge, so the new geometry starts cleanly at (0,0).
    assign frame_end = h_wrap && v_wrap;
    assign req_ok    = axis_valid(h_req) && axis_valid(v_req);

    video_timing_axis u_h_axis (
        .clk    (CLK_VIDEO),
        .rst_n  (RESET_N),
        .step   (CE_PIXEL),
        .cfg    (h_shadow),
        .cnt    (h_cnt),
        .active (h_active),
        .sync   (h_sync),
        .wrap   (h_wrap)
    );

    // Vertical position only moves at a line wrap, which also makes VS
    // change only at the start of a line.
    video_timing_axis u_v_axis (
        .clk    (CLK_VIDEO),
        .rst_n  (RESET_N),
        .step   (CE_PIXEL && h_wrap),
        .cfg    (v_shadow),
        .cnt    (v_cnt),
        .active (v_active),
        .sync   (v_sync),
        .wrap   (v_wrap)
    );

    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            h_shadow    <= H_DEFAULT;
            v_shadow    <= V_DEFAULT;
            VGA_HS      <= 1'b0;
            VGA_VS      <= 1'b0;
            VGA_DE      <= 1'b0;
            HCNT        <= 12'd0;
            VCNT        <= 12'd0;
            FRAME_START <= 1'b0;
            CFG_ERR     <= 1'b0;
        end else begin
            // Pulse is cleared on every non-CE clock so it lasts one clock.
            FRAME_START <= CE_PIXEL && (h_cnt == 12'd0) && (v_cnt == 12'd0);
            if (CE_PIXEL) begin
                VGA_DE <= h_active && v_active;
                VGA_HS <= h_sync;
                VGA_VS <= v_sync;
                HCNT   <= h_cnt;
                VCNT   <= v_cnt;
                if (frame_end) begin
                    if (req_ok) begin
                        h_shadow <= h_req;
                        v_shadow <= v_req;
                        CFG_ERR  <= 1'b0;
                    end else begin
                        CFG_ERR  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_gen
// Purpose  : Directed self-checking bench for video_timing_gen. A reduced
//            raster (24x10) instance covers frame-level behaviour; a second
//            instance with 640x480 defaults covers the native line layout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    localparam int S_HA = 16, S_HFP = 2, S_HS = 3, S_HBP = 3;
    localparam int S_VA = 6,  S_VFP = 1, S_VS = 2, S_VBP = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b1;
    logic [11:0] h_active, h_fp, h_sync, h_bp;
    logic [11:0] v_active, v_fp, v_sync, v_bp;

    logic        hs, vs, de, fs, err;
    logic [11:0] hcnt, vcnt;
    logic        hs_d, vs_d, de_d, fs_d, err_d;
    logic [11:0] hcnt_d, vcnt_d;

    logic [28:0] obs;
    logic [28:0] obs_def;
    logic [28:0] exp_v;

    int checks = 0;
    int errors = 0;

    assign obs     = {hcnt, vcnt, de, hs, vs, fs, err};
    assign obs_def = {hcnt_d, vcnt_d, de_d, hs_d, vs_d, fs_d, err_d};

    always #5 clk = ~clk;

    video_timing_gen #(
        .DEF_HA(S_HA), .DEF_HFP(S_HFP), .DEF_HS(S_HS), .DEF_HBP(S_HBP),
        .DEF_VA(S_VA), .DEF_VFP(S_VFP), .DEF_VS(S_VS), .DEF_VBP(S_VBP)
    ) dut (
        .CLK_VIDEO(clk), .RESET_N(rst_n), .CE_PIXEL(ce),
        .H_ACTIVE(h_active), .H_FP(h_fp), .H_SYNC(h_sync), .H_BP(h_bp),
        .V_ACTIVE(v_active), .V_FP(v_fp), .V_SYNC(v_sync), .V_BP(v_bp),
        .VGA_HS(hs), .VGA_VS(vs), .VGA_DE(de), .HCNT(hcnt), .VCNT(vcnt),
        .FRAME_START(fs), .CFG_ERR(err)
    );

    video_timing_gen dut_def (
        .CLK_VIDEO(clk), .RESET_N(rst_n), .CE_PIXEL(ce),
        .H_ACTIVE(h_active), .H_FP(h_fp), .H_SYNC(h_sync), .H_BP(h_bp),
        .V_ACTIVE(v_active), .V_FP(v_fp), .V_SYNC(v_sync), .V_BP(v_bp),
        .VGA_HS(hs_d), .VGA_VS(vs_d), .VGA_DE(de_d), .HCNT(hcnt_d), .VCNT(vcnt_d),
        .FRAME_START(fs_d), .CFG_ERR(err_d)
    );

    // Expected output vector for the k-th emitted pixel of a frame sequence
    // with the given geometry.
    function automatic logic [28:0] expect_vec(input int k,
            input int ha, input int hfp, input int hsw, input int hbp,
            input int va, input int vfp, input int vsw, input int vbp,
            input logic fs_en, input logic err_exp);
        int htot = ha + hfp + hsw + hbp;
        int vtot = va + vfp + vsw + vbp;
        int h = k % htot;
        int v = (k / htot) % vtot;
        logic e_de = (h < ha) && (v < va);
        logic e_hs = (h >= ha + hfp) && (h < ha + hfp + hsw);
        logic e_vs = (v >= va + vfp) && (v < va + vfp + vsw);
        logic e_fs = fs_en && (h == 0) && (v == 0);
        return {12'(h), 12'(v), e_de, e_hs, e_vs, e_fs, err_exp};
    endfunction

    function automatic string fmt(input logic [28:0] x);
        return $sformatf("h=%0d v=%0d de=%0b hs=%0b vs=%0b fs=%0b err=%0b",
                         x[28:17], x[16:5], x[4], x[3], x[2], x[1], x[0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int ha, input int hfp, input int hsw, input int hbp,
                           input int va, input int vfp, input int vsw, input int vbp);
        h_active = 12'(ha); h_fp = 12'(hfp); h_sync = 12'(hsw); h_bp = 12'(hbp);
        v_active = 12'(va); v_fp = 12'(vfp); v_sync = 12'(vsw); v_bp = 12'(vbp);
    endtask

    // Leaves rst_n released just after an edge; the next edge is CE #0.
    task automatic apply_reset();
        tick();
        rst_n = 1'b0;
        ce    = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_cfg(S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP);
        rst_n = 1'b0;
        ce    = 1'b1;
        repeat (3) tick();
        checks++;
        if (obs !== 29'd0) begin
            errors++;
            $display("FAIL reset_small got %s expected all zero", fmt(obs));
        end
        checks++;
        if (obs_def !== 29'd0) begin
            errors++;
            $display("FAIL reset_def got %s expected all zero", fmt(obs_def));
        end
        rst_n = 1'b1;
    endtask

    task automatic test_native_640();
        for (int k = 0; k < 1700; k++) begin
            tick();
            exp_v = expect_vec(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b0);
            checks++;
            if (obs_def !== exp_v) begin
                errors++;
                $display("FAIL native_640 k=%0d got %s expected %s", k, fmt(obs_def), fmt(exp_v));
            end
        end
    endtask

    task automatic test_default_timing();
        apply_reset();
        for (int k = 0; k <= 240; k++) begin
            tick();
            exp_v = expect_vec(k, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL default_timing k=%0d got %s expected %s", k, fmt(obs), fmt(exp_v));
            end
        end
    endtask

    task automatic test_ce_div3();
        apply_reset();
        for (int c = 0; c <= 720; c++) begin
            tick();
            exp_v = expect_vec(c / 3, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP,
                               (c % 3) == 0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL ce_div3 clk=%0d got %s expected %s", c, fmt(obs), fmt(exp_v));
            end
            ce = ((c + 1) % 3) == 0;
        end
        ce = 1'b1;
    endtask

    task automatic test_hactive_change();
        apply_reset();
        for (int k = 0; k <= 520; k++) begin
            tick();
            if (k < 240)
                exp_v = expect_vec(k, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b1, 1'b0);
            else
                exp_v = expect_vec(k - 240, 20, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL hactive_change k=%0d got %s expected %s", k, fmt(obs), fmt(exp_v));
            end
            if (k == 72) h_active = 12'd20;
        end
        h_active = 12'(S_HA);
    endtask

    task automatic test_cfg_err();
        apply_reset();
        for (int k = 0; k <= 480; k++) begin
            tick();
            exp_v = expect_vec(k, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP,
                               1'b1, (k >= 239) && (k < 479));
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL cfg_err k=%0d got %s expected %s", k, fmt(obs), fmt(exp_v));
            end
            if (k == 100) v_active = 12'd0;
            if (k == 300) v_active = 12'(S_VA);
        end
    endtask

    task automatic test_zero_porch();
        apply_reset();
        set_cfg(4, 0, 2, 0, S_VA, S_VFP, S_VS, S_VBP);
        for (int k = 0; k <= 320; k++) begin
            tick();
            if (k < 240)
                exp_v = expect_vec(k, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b1, 1'b0);
            else
                exp_v = expect_vec(k - 240, 4, 0, 2, 0, S_VA, S_VFP, S_VS, S_VBP, 1'b1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL zero_porch k=%0d got %s expected %s", k, fmt(obs), fmt(exp_v));
            end
        end
    endtask

    // Runs straight on from test_zero_porch: shadow holds the 6-pixel line,
    // inputs still request it, and the DUT sits mid-frame with DE high.
    task automatic test_reset_midframe();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 29'd0) begin
            errors++;
            $display("FAIL reset_async got %s expected all zero", fmt(obs));
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            exp_v = expect_vec(k, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_restart k=%0d got %s expected %s", k, fmt(obs), fmt(exp_v));
            end
        end
    endtask

    initial begin
        test_reset();
        test_native_640();
        test_default_timing();
        test_ce_div3();
        test_hactive_change();
        test_cfg_err();
        test_zero_porch();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Programmable raster timing generator: the transmitting end of the VGA_HS/VGA_VS/VGA_DE interface that the scaler/crop path measures.
- Drives sync and display-enable for test patterns, cores with a fixed native raster, and re-timed output.
- Timing parameters are double-buffered: new values take effect only at the frame boundary, so the downstream hsize/vsize measurement never sees a torn frame.

Parameters:
- DEF_HA, 640, default horizontal active pixels
- DEF_HFP, 16, default horizontal front porch
- DEF_HS, 96, default horizontal sync width
- DEF_HBP, 48, default horizontal back porch
- DEF_VA, 480, default vertical active lines
- DEF_VFP, 10, default vertical front porch
- DEF_VS, 2, default vertical sync width
- DEF_VBP, 33, default vertical back porch

Ports:
- CLK_VIDEO  in  1  video clock
- RESET_N  in  1  asynchronous active-low reset
- CE_PIXEL  in  1  pixel enable; all timing advances only on cycles where CE_PIXEL=1
- H_ACTIVE, H_FP, H_SYNC, H_BP  in  12 each  requested horizontal timing
- V_ACTIVE, V_FP, V_SYNC, V_BP  in  12 each  requested vertical timing
- VGA_HS  out  1  horizontal sync, active high
- VGA_VS  out  1  vertical sync, active high
- VGA_DE  out  1  display enable
- HCNT  out  12  pixel index of the current output position
- VCNT  out  12  line index of the current output position
- FRAME_START  out  1  one-clock pulse when position (0,0) is emitted
- CFG_ERR  out  1  sticky flag: last frame-boundary sample was invalid; cleared by the next valid sample

Behaviour:
- Reset (async assert, sync release):
  - Outputs VGA_HS, VGA_VS, VGA_DE, FRAME_START, CFG_ERR = 0; HCNT = VCNT = 0.
  - Internal counters h = v = 0; shadow config = DEF_* parameters.
- Horizontal layout per line: active [0, HA), then FP, then SYNC, then BP.
  - HTOT = HA+HFP+HS+HBP. Vertical layout and VTOT follow the same order.
- On each CE_PIXEL cycle, outputs register the decode of the current (h,v), then counters advance. Latency is 1 clk: outputs change only in the clock after a CE cycle.
- Advance rules:
  - h = h+1; when h = HTOT-1, h wraps to 0 and v advances.
  - When v = VTOT-1 at that same wrap, v wraps to 0.
- Decode:
  - DE = (h < HA) && (v < VA).
  - HS = HA+HFP <= h < HA+HFP+HS.
  - VS = VA+VFP <= v < VA+VFP+VS; VS changes only at a line start (h = 0).
  - HCNT = h, VCNT = v.
- FRAME_START = 1 for exactly the CE cycle emitting (0,0); 0 otherwise, including non-CE clocks.
- Shadow load, at the CE where h = HTOT-1 and v = VTOT-1:
  - Sample the inputs and sum HTOT/VTOT in 14-bit arithmetic.
  - Valid: HA ≠ 0, VA ≠ 0, HS ≠ 0, VS ≠ 0, HTOT ≤ 4095, VTOT ≤ 4095.
  - Valid sample: shadow = inputs, CFG_ERR = 0. Invalid sample: shadow unchanged, CFG_ERR = 1.
- Zero porches (FP/BP = 0) are legal: sync immediately follows or precedes active.
- CE_PIXEL low: all outputs and state hold, with no drift for any CE duty cycle.
- Reset mid-frame: outputs clear immediately (async). After release, the first CE emits (0,0) using the DEF_* timing, not the pre-reset shadow.
- Input changes mid-frame have no effect until the next frame boundary.

Decomposition:
- Package video_timing_pkg: typedef struct timing_axis_t {active, fp, sync, bp : 12 bits}; DEF_* constants; function axis_valid().
- Sub-module video_timing_axis, instantiated twice (horizontal and vertical). Contents: counter, wrap detect, region compare. Inputs: step enable and shadowed timing_axis_t. Outputs: cnt, active, sync, wrap.

Test Plan:
- Defaults with CE_PIXEL = 1:
  - 640 DE pixels per line; HS high for h 656..751 (96 clocks); HTOT = 800.
  - VS high on lines 490..491; FRAME_START period = 420000 clocks.
- CE_PIXEL every 3rd clock: identical output sequence stretched ×3; FRAME_START period = 1260000 clocks; outputs stable between CEs.
- H_ACTIVE changed 640→720 at line 100:
  - Current frame keeps 640-pixel DE.
  - Next frame after FRAME_START has 720-pixel DE, HTOT = 880.
- V_ACTIVE = 0 written:
  - CFG_ERR = 1 at the boundary; timing stays 640x480.
  - Restoring 480 → CFG_ERR = 0 at the next boundary.
- H_FP = 0, H_BP = 0, HA = 4, HS = 2: HS rises at h = 4 directly after DE falls; line period = 6 CE.
- RESET_N pulsed low at (h = 300, v = 200) mid-frame:
  - All outputs 0 asynchronously.
  - First CE after release emits DE = 1, HCNT = 0, VCNT = 0, FRAME_START = 1.
